// File: rtl/add_rs_dispatch.sv
// add_rs_dispatch: reservation station + dispatch for the add/sub unit.
// Entries capture CDB broadcasts, the ready entry with priority is sent to
// the single execution unit with a one-cycle ex_b strobe, and done_valid
// frees it again.
// Optional ADD_RS_AGE_SELECT_EN: oldest-ready-entry selection via per-entry
// saturating age counters; undefined gives lowest-ready-index selection.

module add_rs_entry #(
  parameter int DW   = 8,
  parameter int RW   = 4,
  parameter int ROBW = 3,
  parameter int AGEW = 3
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            alloc_we,
  input  logic [3:0]      a_func,
  input  logic [RW-1:0]   a_rd,
  input  logic [ROBW-1:0] a_rob,
  input  logic            a_s1_rdy,
  input  logic            a_s2_rdy,
  input  logic [DW-1:0]   a_s1_val,
  input  logic [DW-1:0]   a_s2_val,
  input  logic [RW-1:0]   a_s1_tag,
  input  logic [RW-1:0]   a_s2_tag,
  input  logic            cdb_valid,
  input  logic [RW-1:0]   cdb_rd,
  input  logic [DW-1:0]   cdb_data,
  input  logic            issue,
  input  logic            clr,
  output logic            busy,
  output logic            ready,
  output logic [3:0]      func,
  output logic [RW-1:0]   rd,
  output logic [ROBW-1:0] rob,
  output logic [DW-1:0]   d1,
  output logic [DW-1:0]   d2
`ifdef ADD_RS_AGE_SELECT_EN
  ,
  output logic [AGEW-1:0] age
`endif
);
  logic          issued, v1, v2;
  logic [RW-1:0] t1, t2;

  assign ready = busy && !issued && v1 && v2;

  // Entry state: allocation (with same-edge CDB capture), free, issue, wakeup.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; issued <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
      func <= '0; rd <= '0; rob <= '0; d1 <= '0; d2 <= '0; t1 <= '0; t2 <= '0;
    end else if (alloc_we) begin
      busy   <= 1'b1;
      issued <= 1'b0;
      func   <= a_func;
      rd     <= a_rd;
      rob    <= a_rob;
      t1     <= a_s1_tag;
      t2     <= a_s2_tag;
      v1     <= a_s1_rdy || (cdb_valid && a_s1_tag == cdb_rd);
      v2     <= a_s2_rdy || (cdb_valid && a_s2_tag == cdb_rd);
      d1     <= a_s1_rdy ? a_s1_val : cdb_data;
      d2     <= a_s2_rdy ? a_s2_val : cdb_data;
    end else if (clr) begin
      busy   <= 1'b0;
      issued <= 1'b0;
    end else if (busy) begin
      if (issue) issued <= 1'b1;
      if (cdb_valid && !v1 && t1 == cdb_rd) begin v1 <= 1'b1; d1 <= cdb_data; end
      if (cdb_valid && !v2 && t2 == cdb_rd) begin v2 <= 1'b1; d2 <= cdb_data; end
    end
  end

`ifdef ADD_RS_AGE_SELECT_EN
  // Age: zero on allocation, counts edges while busy, saturates at all-ones.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)                 age <= '0;
    else if (alloc_we)          age <= '0;
    else if (busy && age != '1) age <= age + 1'b1;
  end
`endif
endmodule

module add_rs_dispatch #(
  parameter int N_ENT = 3,
  parameter int DW    = 8,
  parameter int RW    = 4,
  parameter int ROBW  = 3
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [3:0]                 alloc_func,
  input  logic [RW-1:0]              alloc_rd,
  input  logic [ROBW-1:0]            alloc_rob,
  input  logic                       alloc_s1_rdy,
  input  logic                       alloc_s2_rdy,
  input  logic [DW-1:0]              alloc_s1_val,
  input  logic [DW-1:0]              alloc_s2_val,
  input  logic [RW-1:0]              alloc_s1_tag,
  input  logic [RW-1:0]              alloc_s2_tag,
  input  logic                       cdb_valid,
  input  logic [RW-1:0]              cdb_rd,
  input  logic [DW-1:0]              cdb_data,
  output logic                       ex_b,
  output logic [2:0]                 rs_index,
  output logic [DW-1:0]              rs1_data,
  output logic [DW-1:0]              rs2_data,
  output logic [3:0]                 func,
  output logic [RW-1:0]              rd,
  output logic [ROBW-1:0]            rob_ind,
  input  logic                       done_valid,
  input  logic [2:0]                 done_index,
  output logic [$clog2(N_ENT+1)-1:0] occ
);
  localparam int IW   = $clog2(N_ENT);
  localparam int OCCW = $clog2(N_ENT+1);
  localparam int AGEW = N_ENT;

  logic [N_ENT-1:0]           busy, ready, alloc_we, issue, clr;
  logic [N_ENT-1:0][3:0]      e_func;
  logic [N_ENT-1:0][RW-1:0]   e_rd;
  logic [N_ENT-1:0][ROBW-1:0] e_rob;
  logic [N_ENT-1:0][DW-1:0]   e_d1, e_d2;
`ifdef ADD_RS_AGE_SELECT_EN
  logic [N_ENT-1:0][AGEW-1:0] e_age;
  logic [AGEW-1:0]            sel_age;
`endif
  logic          alloc_hit, alloc_fire, sel_hit, unit_busy, unit_free, disp, done_dec;
  logic [IW-1:0] alloc_idx, sel_idx;

  for (genvar g = 0; g < N_ENT; g++) begin : g_ent
    assign alloc_we[g] = alloc_fire && alloc_idx == IW'(g);
    assign issue[g]    = disp && sel_idx == IW'(g);
    assign clr[g]      = done_valid && done_index == 3'(g);
    add_rs_entry #(.DW(DW), .RW(RW), .ROBW(ROBW), .AGEW(AGEW)) u_ent (
      .clk1(clk1), .rst_n(rst_n), .alloc_we(alloc_we[g]),
      .a_func(alloc_func), .a_rd(alloc_rd), .a_rob(alloc_rob),
      .a_s1_rdy(alloc_s1_rdy), .a_s2_rdy(alloc_s2_rdy),
      .a_s1_val(alloc_s1_val), .a_s2_val(alloc_s2_val),
      .a_s1_tag(alloc_s1_tag), .a_s2_tag(alloc_s2_tag),
      .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
      .issue(issue[g]), .clr(clr[g]),
      .busy(busy[g]), .ready(ready[g]), .func(e_func[g]), .rd(e_rd[g]),
      .rob(e_rob[g]), .d1(e_d1[g]), .d2(e_d2[g])
`ifdef ADD_RS_AGE_SELECT_EN
      , .age(e_age[g])
`endif
    );
  end

  // Lowest-index free entry receives the next allocation.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = N_ENT-1; i >= 0; i--)
      if (!busy[i]) begin alloc_hit = 1'b1; alloc_idx = IW'(i); end
  end

  assign alloc_ready = alloc_hit;
  assign alloc_fire  = alloc_valid && alloc_hit;

  // Dispatch winner among ready entries (oldest first when ages exist).
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
`ifdef ADD_RS_AGE_SELECT_EN
    sel_age = '0;
    for (int i = 0; i < N_ENT; i++)
      if (ready[i] && (!sel_hit || e_age[i] > sel_age)) begin
        sel_hit = 1'b1; sel_idx = IW'(i); sel_age = e_age[i];
      end
`else
    for (int i = 0; i < N_ENT; i++)
      if (ready[i] && !sel_hit) begin sel_hit = 1'b1; sel_idx = IW'(i); end
`endif
  end

  assign unit_free = !unit_busy || done_valid;
  assign disp      = sel_hit && unit_free;
  assign done_dec  = |(clr & busy);

  // Registered dispatch outputs; data holds between strobes.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ex_b <= 1'b0; rs_index <= '0; rs1_data <= '0; rs2_data <= '0;
      func <= '0; rd <= '0; rob_ind <= '0;
    end else begin
      ex_b <= disp;
      if (disp) begin
        rs_index <= 3'(sel_idx);
        rs1_data <= e_d1[sel_idx];
        rs2_data <= e_d2[sel_idx];
        func     <= e_func[sel_idx];
        rd       <= e_rd[sel_idx];
        rob_ind  <= e_rob[sel_idx];
      end
    end
  end

  // Execution unit occupancy and busy-entry count.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      unit_busy <= 1'b0;
      occ       <= '0;
    end else begin
      if (disp)            unit_busy <= 1'b1;
      else if (done_valid) unit_busy <= 1'b0;
      occ <= occ + OCCW'(alloc_fire) - OCCW'(done_dec);
    end
  end
endmodule

// File: tb/tb_add_rs_dispatch.sv
// Bench for add_rs_dispatch: directed scenarios plus a randomized run against
// an entry-table reference model.
module tb_add_rs_dispatch;
  localparam int N = 3;

  logic       clk1 = 1'b0, rst_n = 1'b0;
  logic       alloc_valid, alloc_ready, alloc_s1_rdy, alloc_s2_rdy;
  logic [3:0] alloc_func, alloc_rd, alloc_s1_tag, alloc_s2_tag, cdb_rd, func, rd;
  logic [2:0] alloc_rob, rs_index, rob_ind, done_index;
  logic [7:0] alloc_s1_val, alloc_s2_val, cdb_data, rs1_data, rs2_data;
  logic       cdb_valid, ex_b, done_valid;
  logic [1:0] occ;

  int vectors = 0, miscompares = 0;

  add_rs_dispatch dut (
    .clk1(clk1), .rst_n(rst_n), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_rob(alloc_rob),
    .alloc_s1_rdy(alloc_s1_rdy), .alloc_s2_rdy(alloc_s2_rdy),
    .alloc_s1_val(alloc_s1_val), .alloc_s2_val(alloc_s2_val),
    .alloc_s1_tag(alloc_s1_tag), .alloc_s2_tag(alloc_s2_tag),
    .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
    .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rd(rd), .rob_ind(rob_ind),
    .done_valid(done_valid), .done_index(done_index), .occ(occ)
  );

  always #5 clk1 = ~clk1;

  // {ex_b, rs_index, rs1_data, rs2_data, func, rd, rob_ind}
  wire [30:0] obs = {ex_b, rs_index, rs1_data, rs2_data, func, rd, rob_ind};

  task automatic tick;
    @(posedge clk1); #1;
  endtask

  task automatic idle;
    alloc_valid = 0; alloc_func = 0; alloc_rd = 0; alloc_rob = 0;
    alloc_s1_rdy = 0; alloc_s2_rdy = 0; alloc_s1_val = 0; alloc_s2_val = 0;
    alloc_s1_tag = 0; alloc_s2_tag = 0;
    cdb_valid = 0; cdb_rd = 0; cdb_data = 0; done_valid = 0; done_index = 0;
  endtask

  task automatic apply_reset;
    idle;
    rst_n = 0;
    repeat (2) @(posedge clk1);
    #3 rst_n = 1;
    tick;
  endtask

  task automatic set_alloc(input logic [3:0] f, input logic [3:0] d, input logic [2:0] r,
                           input logic s1r, input logic [7:0] s1v, input logic [3:0] s1t,
                           input logic s2r, input logic [7:0] s2v, input logic [3:0] s2t);
    alloc_valid = 1; alloc_func = f; alloc_rd = d; alloc_rob = r;
    alloc_s1_rdy = s1r; alloc_s1_val = s1v; alloc_s1_tag = s1t;
    alloc_s2_rdy = s2r; alloc_s2_val = s2v; alloc_s2_tag = s2t;
  endtask

  // ---------------- reference model ----------------
  bit         m_busy[N], m_iss[N], m_v1[N], m_v2[N], m_ub;
  bit [7:0]   m_d1[N], m_d2[N];
  bit [3:0]   m_t1[N], m_t2[N], m_func[N], m_rd[N];
  bit [2:0]   m_rob[N], m_age[N];
  bit [30:0]  m_obs;
  int         m_occ;

  task automatic model_reset;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_iss[i] = 0; m_v1[i] = 0; m_v2[i] = 0; m_age[i] = 0;
    end
    m_ub = 0; m_obs = '0; m_occ = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step;
    int a = -1, w = -1;
    for (int i = N-1; i >= 0; i--) if (!m_busy[i]) a = i;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_iss[i] && m_v1[i] && m_v2[i]) begin
`ifdef ADD_RS_AGE_SELECT_EN
        if (w < 0 || m_age[i] > m_age[w]) w = i;
`else
        if (w < 0) w = i;
`endif
      end
    if (w >= 0 && (!m_ub || done_valid))
      m_obs = {1'b1, 3'(w), m_d1[w], m_d2[w], m_func[w], m_rd[w], m_rob[w]};
    else begin
      m_obs[30] = 1'b0; w = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && m_age[i] != 3'(2**N - 1)) m_age[i]++;
      if (m_busy[i] && cdb_valid && !m_v1[i] && m_t1[i] == cdb_rd) begin m_v1[i] = 1; m_d1[i] = cdb_data; end
      if (m_busy[i] && cdb_valid && !m_v2[i] && m_t2[i] == cdb_rd) begin m_v2[i] = 1; m_d2[i] = cdb_data; end
    end
    if (done_valid && done_index < N && m_busy[done_index]) begin
      m_busy[done_index] = 0; m_iss[done_index] = 0; m_occ--;
    end
    if (w >= 0) begin m_iss[w] = 1; m_ub = 1; end
    else if (done_valid) m_ub = 0;
    if (alloc_valid && a >= 0) begin
      m_busy[a] = 1; m_iss[a] = 0; m_age[a] = 0;
      m_func[a] = alloc_func; m_rd[a] = alloc_rd; m_rob[a] = alloc_rob;
      m_t1[a] = alloc_s1_tag; m_t2[a] = alloc_s2_tag;
      m_v1[a] = alloc_s1_rdy || (cdb_valid && alloc_s1_tag == cdb_rd);
      m_v2[a] = alloc_s2_rdy || (cdb_valid && alloc_s2_tag == cdb_rd);
      m_d1[a] = alloc_s1_rdy ? alloc_s1_val : cdb_data;
      m_d2[a] = alloc_s2_rdy ? alloc_s2_val : cdb_data;
      m_occ++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    apply_reset;
    vectors++;
    if (obs !== 31'd0 || occ !== 2'd0 || alloc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_values: obs=%h occ=%0d ready=%0b, want obs=0 occ=0 ready=1", obs, occ, alloc_ready);
    end
    set_alloc(4'd0, 4'd1, 3'd1, 1, 8'd11, 4'd0, 1, 8'd12, 4'd0); tick;
    set_alloc(4'd1, 4'd2, 3'd2, 1, 8'd13, 4'd0, 1, 8'd14, 4'd0); tick;
    idle;
    vectors++;
    if (occ !== 2'd2 || ex_b !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_setup: occ=%0d ex_b=%0b, want occ=2 ex_b=1", occ, ex_b);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if (occ !== 2'd0 || ex_b !== 1'b0 || alloc_ready !== 1'b1 || rs1_data !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_async: occ=%0d ex_b=%0b ready=%0b rs1=%0d, want 0 0 1 0", occ, ex_b, alloc_ready, rs1_data);
    end
    @(negedge clk1); rst_n = 1;
    tick;
    done_valid = 1; done_index = 0; tick; idle;
    vectors++;
    if (occ !== 2'd0 || ex_b !== 1'b0 || alloc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stale_done: occ=%0d ex_b=%0b ready=%0b, want 0 0 1", occ, ex_b, alloc_ready);
    end
  endtask

  task automatic test_ready_alloc;
    apply_reset;
    set_alloc(4'd0, 4'd2, 3'd1, 1, 8'd5, 4'd0, 1, 8'd3, 4'd0); tick; idle;
    vectors++;
    if (ex_b !== 1'b0) begin miscompares++; $display("FAIL ready_alloc_early: ex_b=%0b want 0", ex_b); end
    tick;
    vectors++;
    if (obs !== {1'b1, 3'd0, 8'd5, 8'd3, 4'd0, 4'd2, 3'd1}) begin
      miscompares++; $display("FAIL ready_alloc_dispatch: obs=%h want %h", obs, {1'b1, 3'd0, 8'd5, 8'd3, 4'd0, 4'd2, 3'd1});
    end
    tick;
    vectors++;
    if (ex_b !== 1'b0) begin miscompares++; $display("FAIL ready_alloc_pulse: ex_b=%0b want 0", ex_b); end
    done_valid = 1; done_index = 0; tick; idle;
    vectors++;
    if (occ !== 2'd0 || alloc_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_alloc_free: occ=%0d ready=%0b want 0 1", occ, alloc_ready);
    end
  endtask

  task automatic test_cdb_wakeup;
    apply_reset;
    set_alloc(4'd1, 4'd5, 3'd2, 0, 8'd0, 4'd4, 1, 8'd7, 4'd0); tick; idle; tick;
    vectors++;
    if (ex_b !== 1'b0 || occ !== 2'd1) begin
      miscompares++; $display("FAIL cdb_waiting: ex_b=%0b occ=%0d want 0 1", ex_b, occ);
    end
    cdb_valid = 1; cdb_rd = 4'd4; cdb_data = 8'd9;
    set_alloc(4'd0, 4'd6, 3'd3, 0, 8'd0, 4'd4, 1, 8'd1, 4'd0); tick; idle;
    vectors++;
    if (ex_b !== 1'b0 || occ !== 2'd2) begin
      miscompares++; $display("FAIL cdb_no_forward: ex_b=%0b occ=%0d want 0 2", ex_b, occ);
    end
    tick;
    vectors++;
    if (obs !== {1'b1, 3'd0, 8'd9, 8'd7, 4'd1, 4'd5, 3'd2}) begin
      miscompares++; $display("FAIL cdb_wakeup_dispatch: obs=%h want %h", obs, {1'b1, 3'd0, 8'd9, 8'd7, 4'd1, 4'd5, 3'd2});
    end
    done_valid = 1; done_index = 0; tick; idle;
    vectors++;
    if (obs !== {1'b1, 3'd1, 8'd9, 8'd1, 4'd0, 4'd6, 3'd3}) begin
      miscompares++; $display("FAIL cdb_alloc_capture: obs=%h want %h", obs, {1'b1, 3'd1, 8'd9, 8'd1, 4'd0, 4'd6, 3'd3});
    end
    done_valid = 1; done_index = 1; tick; idle;
    vectors++;
    if (occ !== 2'd0 || ex_b !== 1'b0) begin
      miscompares++; $display("FAIL cdb_drain: occ=%0d ex_b=%0b want 0 0", occ, ex_b);
    end
  endtask

  task automatic test_unit_busy;
    apply_reset;
    for (int i = 0; i < 3; i++) begin
      set_alloc(4'd0, 4'(i), 3'(i), 1, 8'(10 + i), 4'd0, 1, 8'(i), 4'd0); tick;
      if (i == 1) begin
        vectors++;
        if (ex_b !== 1'b1 || rs_index !== 3'd0 || rs1_data !== 8'd10) begin
          miscompares++; $display("FAIL busy_first: ex_b=%0b idx=%0d rs1=%0d want 1 0 10", ex_b, rs_index, rs1_data);
        end
      end
    end
    idle;
    vectors++;
    if (occ !== 2'd3 || alloc_ready !== 1'b0 || ex_b !== 1'b0) begin
      miscompares++; $display("FAIL busy_full: occ=%0d ready=%0b ex_b=%0b want 3 0 0", occ, alloc_ready, ex_b);
    end
    set_alloc(4'd0, 4'd9, 3'd7, 1, 8'd99, 4'd0, 1, 8'd99, 4'd0); tick; idle;
    vectors++;
    if (occ !== 2'd3 || ex_b !== 1'b0) begin
      miscompares++; $display("FAIL busy_drop: occ=%0d ex_b=%0b want 3 0", occ, ex_b);
    end
    for (int k = 1; k < 3; k++) begin
      done_valid = 1; done_index = 3'(k - 1); tick; idle;
      vectors++;
      if (ex_b !== 1'b1 || rs_index !== 3'(k) || rs1_data !== 8'(10 + k) || occ !== 2'(3 - k)) begin
        miscompares++;
        $display("FAIL busy_order_%0d: ex_b=%0b idx=%0d rs1=%0d occ=%0d want 1 %0d %0d %0d", k, ex_b, rs_index, rs1_data, occ, k, 10 + k, 3 - k);
      end
      tick;
      vectors++;
      if (ex_b !== 1'b0) begin miscompares++; $display("FAIL busy_wait_%0d: ex_b=%0b want 0", k, ex_b); end
    end
    done_valid = 1; done_index = 2; tick; idle;
    vectors++;
    if (occ !== 2'd0 || ex_b !== 1'b0 || alloc_ready !== 1'b1) begin
      miscompares++; $display("FAIL busy_drain: occ=%0d ex_b=%0b ready=%0b want 0 0 1", occ, ex_b, alloc_ready);
    end
  endtask

  task automatic test_back_to_back;
    apply_reset;
    set_alloc(4'd0, 4'd3, 3'd4, 1, 8'd21, 4'd0, 1, 8'd22, 4'd0); tick;
    set_alloc(4'd1, 4'd4, 3'd5, 1, 8'd31, 4'd0, 1, 8'd32, 4'd0); tick; idle;
    vectors++;
    if (ex_b !== 1'b1 || rs_index !== 3'd0) begin
      miscompares++; $display("FAIL b2b_first: ex_b=%0b idx=%0d want 1 0", ex_b, rs_index);
    end
    done_valid = 1; done_index = 0; tick; idle;
    vectors++;
    if (obs !== {1'b1, 3'd1, 8'd31, 8'd32, 4'd1, 4'd4, 3'd5} || occ !== 2'd1) begin
      miscompares++; $display("FAIL b2b_second: obs=%h occ=%0d want %h 1", obs, occ, {1'b1, 3'd1, 8'd31, 8'd32, 4'd1, 4'd4, 3'd5});
    end
    done_valid = 1; done_index = 1; tick; idle;
  endtask

  task automatic test_age_order;
    logic [2:0] first, second;
`ifdef ADD_RS_AGE_SELECT_EN
    first = 3'd2; second = 3'd0;
`else
    first = 3'd0; second = 3'd2;
`endif
    apply_reset;
    set_alloc(4'd0, 4'd1, 3'd1, 1, 8'd20, 4'd0, 1, 8'd1, 4'd0); tick;
    set_alloc(4'd0, 4'd2, 3'd2, 0, 8'd0, 4'd6, 1, 8'd9, 4'd0); tick;
    set_alloc(4'd0, 4'd3, 3'd3, 0, 8'd0, 4'd5, 1, 8'd2, 4'd0);
    done_valid = 1; done_index = 0; tick; idle;
    set_alloc(4'd0, 4'd4, 3'd4, 0, 8'd0, 4'd5, 1, 8'd3, 4'd0); tick; idle;
    cdb_valid = 1; cdb_rd = 4'd5; cdb_data = 8'd40; tick; idle;
    tick;
    vectors++;
    if (ex_b !== 1'b1 || rs_index !== first || rs1_data !== 8'd40) begin
      miscompares++; $display("FAIL age_first: ex_b=%0b idx=%0d rs1=%0d want 1 %0d 40", ex_b, rs_index, rs1_data, first);
    end
    done_valid = 1; done_index = first; tick; idle;
    vectors++;
    if (ex_b !== 1'b1 || rs_index !== second) begin
      miscompares++; $display("FAIL age_second: ex_b=%0b idx=%0d want 1 %0d", ex_b, rs_index, second);
    end
  endtask

  task automatic test_random;
    apply_reset;
    model_reset;
    for (int c = 0; c < 800; c++) begin
      idle;
      if ($urandom_range(0, 9) < 6)
        set_alloc(4'($urandom), 4'($urandom), 3'($urandom),
                  1'($urandom_range(0, 2) == 0), 8'($urandom), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), 8'($urandom), 4'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) < 4) begin
        cdb_valid = 1; cdb_rd = 4'($urandom_range(0, 3)); cdb_data = 8'($urandom);
      end
      if (m_ub && $urandom_range(0, 2) == 0) begin
        done_valid = 1; done_index = m_obs[29:27];
      end else if (!m_ub && $urandom_range(0, 7) == 0) begin
        done_index = 3'($urandom);
        done_valid = (done_index >= N) || !m_busy[done_index];
      end
      model_step;
      tick;
      vectors++;
      if (obs !== m_obs || occ !== 2'(m_occ) || alloc_ready !== (m_occ < N)) begin
        miscompares++;
        $display("FAIL random_c%0d: obs=%h occ=%0d ready=%0b want obs=%h occ=%0d ready=%0b",
                 c, obs, occ, alloc_ready, m_obs, m_occ, m_occ < N);
      end
    end
    idle;
  endtask

  initial begin
    idle;
    test_reset;
    test_ready_alloc;
    test_cdb_wakeup;
    test_unit_busy;
    test_back_to_back;
    test_age_order;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/add_rs_dispatch.md
Name: add_rs_dispatch

Overview:
- Reservation station and dispatch stage for the adder/subtractor execution unit of the Tomasulo core.
- Holds up to N_ENT issued add/sub instructions and captures operand values broadcast on the common data bus.
- Picks one entry with both operands ready and hands it to the single add execution unit with a one-cycle ex_b pulse.
- Frees the entry when the execution unit reports completion.

Parameters:
- N_ENT, 3, number of station entries (2..8)
- DW, 8, operand data width
- RW, 4, architectural register index width
- ROBW, 3, ROB index width

Ports:
- clk1  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_valid  in  1  issue stage presents an add/sub instruction
- alloc_ready  out  1  at least one entry is free
- alloc_func  in  4  0000 add, 0001 sub
- alloc_rd  in  RW  destination register
- alloc_rob  in  ROBW  ROB index
- alloc_s1_rdy, alloc_s2_rdy  in  1 each  source value already available
- alloc_s1_val, alloc_s2_val  in  DW each  source value, used when its rdy flag is 1
- alloc_s1_tag, alloc_s2_tag  in  RW each  producing register, used when its rdy flag is 0
- cdb_valid  in  1  result broadcast
- cdb_rd  in  RW  register being written
- cdb_data  in  DW  broadcast value
- ex_b  out  1  one-cycle dispatch strobe to the execution unit
- rs_index  out  3  entry index being dispatched
- rs1_data, rs2_data  out  DW each  operands
- func  out  4  operation
- rd  out  RW  destination register
- rob_ind  out  ROBW  ROB index
- done_valid  in  1  execution unit finished
- done_index  in  3  entry index that finished
- occ  out  $clog2(N_ENT+1)  number of busy entries

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - All entries cleared to busy=0, issued=0; unit_busy=0.
  - Outputs: ex_b=0, rs_index=0, rs1_data=0, rs2_data=0, func=0, rd=0, rob_ind=0, occ=0, alloc_ready=1.
  - An in-flight execution is forgotten; a later done_valid is ignored.
- Entry fields: busy, issued, func, rd, rob, v1, v2, d1, d2, t1, t2.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Writes the lowest-index free entry; busy=1, issued=0.
  - alloc_ready is combinational: 1 iff any entry has busy=0.
  - alloc_valid while alloc_ready=0 is dropped; the issue stage must hold the request.
- CDB capture (every edge):
  - For each busy entry and each source with v=0 and t==cdb_rd while cdb_valid=1: load d from cdb_data and set v=1.
  - Applies to the entry being allocated in the same cycle: a source arriving with rdy=0 and tag==cdb_rd is stored ready with cdb_data, so no wakeup is lost.
  - A single broadcast may wake both sources of an entry and several entries at once.
- Unit availability:
  - unit_free = !unit_busy || done_valid.
- Selection (combinational, on current state):
  - Candidates are entries with busy && !issued && v1 && v2.
  - Default policy: lowest index wins.
- Dispatch (registered):
  - If a candidate exists and unit_free, the next edge loads rs_index, operands, func, rd and rob_ind from the winner.
  - Same edge: ex_b=1, winner issued=1, unit_busy=1.
  - Otherwise ex_b=0 at that edge; the data outputs hold their previous values.
  - ex_b is never high two consecutive cycles unless done_valid arrived in the first of them.
- Latency:
  - Allocation with both operands ready at edge k gives ex_b high after edge k+1.
  - An operand captured from the CDB at edge k gives ex_b at edge k+1 at the earliest.
  - Operands are not forwarded from cdb_data straight to the outputs in the same cycle.
- Completion (done_valid at an edge):
  - Clears busy and issued of entry done_index; clears unit_busy unless a new dispatch occurs at the same edge.
  - If done_index names a non-busy entry, the entries are unchanged; only unit_busy is cleared.
- Simultaneous events:
  - Allocation may reuse an entry freed by done at the same edge only from the next cycle: alloc_ready reflects pre-edge state.
  - Allocation, CDB capture, done and dispatch may all occur at the same edge, on different entries.
- occ:
  - Registered count of busy entries, updated each edge by +alloc and -done of a busy entry.
  - Stays within 0..N_ENT.
- func values other than 0000/0001 are stored and dispatched unchanged; the execution unit ignores them.

Optional Feature:
- Macro ADD_RS_AGE_SELECT_EN.
- Defined:
  - Each entry carries an age counter: 0 on allocation, +1 at each edge while busy, saturating at 2^N_ENT-1.
  - Selection picks the ready entry with the largest age; ties go to the lower index.
- Undefined: lowest-ready-index selection; no age state is synthesized.

Test Plan:
- Reset mid-run: assert rst_n=0 while unit_busy=1 with 2 entries busy -> occ=0, ex_b=0, alloc_ready=1 immediately, without waiting for a clock edge.
- Ready alloc: func=0000, s1=5, s2=3 (both rdy), rd=2, rob=1 at edge k -> ex_b=1 after k+1 with rs_index=0, rs1_data=5, rs2_data=3, rd=2, rob_ind=1; ex_b=0 the following cycle.
- CDB wakeup: entry waits on t1=4; cdb_valid, cdb_rd=4, cdb_data=9 -> rs1_data=9 dispatched one edge later; same-cycle alloc with tag 4 also captures 9.
- Unit busy: fill 3 ready entries -> occ=3, alloc_ready=0; dispatches occur only after each done_valid, in order 0,1,2; occ decrements on each done.
- Done plus dispatch: done_valid with done_index=0 in the same cycle entry 1 is ready -> entry 1 dispatched at that edge; ex_b high in two consecutive cycles is allowed.
- ADD_RS_AGE_SELECT_EN: entry 2 allocated before entry 0 and both become ready together -> entry 2 dispatched first; without the macro, entry 0 is dispatched first.
